// File: rtl/operand_buf.sv
// Dual-bank (row/column) operand store with per-entry valid bits, stall flags
// and registered 1-cycle reads. Bank 0 serves the row port, bank 1 the column port.
module operand_buf #(
  parameter int S         = 8,
  parameter int addrwidth = 3,
  parameter int DW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [addrwidth:0]   wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [addrwidth:0]   addr_r,
  input  logic [addrwidth:0]   addr_c,
  output logic                 rfflag,
  output logic                 cfflag,
  output logic [DW-1:0]        rd_data_r,
  output logic                 rd_vld_r,
  output logic [DW-1:0]        rd_data_c,
  output logic                 rd_vld_c,
  output logic                 full_r,
  output logic                 full_c
);

  localparam int NB = 2;
  localparam logic [addrwidth:0] S_A = (addrwidth+1)'(S);
  localparam logic [addrwidth:0] ONE = (addrwidth+1)'(1);

  logic [addrwidth:0]   addr [NB];
  logic [NB-1:0]        bank_sel;
  logic [NB-1:0]        flag;
  logic [NB-1:0]        rd_vld;
  logic [NB-1:0]        full;
  logic [DW-1:0]        rd_data [NB];
  logic                 wr_ok;
  logic [addrwidth-1:0] wr_idx;

  assign addr[0]  = addr_r;
  assign addr[1]  = addr_c;
  assign bank_sel = {wr_bank, ~wr_bank};
  // Out-of-range write addresses are dropped entirely, never aliased.
  assign wr_ok    = wr_en && (wr_addr < S_A);
  assign wr_idx   = wr_addr[addrwidth-1:0];

  generate
    for (genvar gb = 0; gb < NB; gb++) begin : g_bank
      logic [DW-1:0]        mem_reg [S];
      logic [S-1:0]         vld_reg;
      logic [S-1:0]         vld_next;
      logic [addrwidth:0]   cnt_reg;
      logic [addrwidth:0]   cnt_next;
      logic                 full_reg;
      logic [DW-1:0]        rd_data_reg;
      logic                 rd_vld_reg;
      logic                 bank_wr;
      logic                 req;
      logic                 hit;
      logic [addrwidth-1:0] rd_idx;

      assign bank_wr = wr_ok && bank_sel[gb];
      assign rd_idx  = addr[gb][addrwidth-1:0];
      assign req     = addr[gb] < S_A;
      assign hit     = req && vld_reg[rd_idx];

      // Clear takes effect before a same-cycle write, so that write always counts.
      always_comb begin
        vld_next = clr ? '0 : vld_reg;
        cnt_next = clr ? '0 : cnt_reg;
        if (bank_wr) begin
          vld_next[wr_idx] = 1'b1;
          if (clr || !vld_reg[wr_idx]) begin
            cnt_next = cnt_next + ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < S; i++) begin
            mem_reg[i] <= '0;
          end
          vld_reg     <= '0;
          cnt_reg     <= '0;
          full_reg    <= 1'b0;
          rd_data_reg <= '0;
          rd_vld_reg  <= 1'b0;
        end else begin
          if (bank_wr) begin
            mem_reg[wr_idx] <= wr_data;
          end
          vld_reg    <= vld_next;
          cnt_reg    <= cnt_next;
          full_reg   <= (cnt_next == S_A);
          rd_vld_reg <= hit;
          // Reads sample the pre-edge contents: read-before-write on collision.
          if (hit) begin
            rd_data_reg <= mem_reg[rd_idx];
          end
        end
      end

      assign flag[gb]    = req && !vld_reg[rd_idx];
      assign rd_vld[gb]  = rd_vld_reg;
      assign full[gb]    = full_reg;
      assign rd_data[gb] = rd_data_reg;
    end
  endgenerate

  assign rfflag    = flag[0];
  assign cfflag    = flag[1];
  assign rd_vld_r  = rd_vld[0];
  assign rd_vld_c  = rd_vld[1];
  assign rd_data_r = rd_data[0];
  assign rd_data_c = rd_data[1];
  assign full_r    = full[0];
  assign full_c    = full[1];

endmodule

// File: tb/tb_operand_buf.sv
// Directed table-driven bench for operand_buf, plus a hand-written
// asynchronous mid-frame reset sequence.
module tb_operand_buf;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       wr_en;
  logic       wr_bank;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] addr_r;
  logic [3:0] addr_c;
  logic       rfflag;
  logic       cfflag;
  logic [7:0] rd_data_r;
  logic       rd_vld_r;
  logic [7:0] rd_data_c;
  logic       rd_vld_c;
  logic       full_r;
  logic       full_c;

  int checks = 0;
  int errors = 0;

  operand_buf #(.S(8), .addrwidth(3), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .addr_r   (addr_r),
    .addr_c   (addr_c),
    .rfflag   (rfflag),
    .cfflag   (cfflag),
    .rd_data_r(rd_data_r),
    .rd_vld_r (rd_vld_r),
    .rd_data_c(rd_data_c),
    .rd_vld_c (rd_vld_c),
    .full_r   (full_r),
    .full_c   (full_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       wr_en;
    logic       wr_bank;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] addr_r;
    logic [3:0] addr_c;
    logic       e_rf;
    logic       e_cf;
    logic       e_vr;
    logic [7:0] e_dr;
    logic       e_vc;
    logic [7:0] e_dc;
    logic       e_fr;
    logic       e_fc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input int c, input int we, input int wb, input int wa,
                              input int wd, input int ar, input int ac,
                              input int rf, input int cf, input int vr, input int dr,
                              input int vc, input int dc, input int fr, input int fc);
    vec_t v;
    v.clr = 1'(c);      v.wr_en = 1'(we);   v.wr_bank = 1'(wb);
    v.wr_addr = 4'(wa); v.wr_data = 8'(wd);
    v.addr_r = 4'(ar);  v.addr_c = 4'(ac);
    v.e_rf = 1'(rf);    v.e_cf = 1'(cf);
    v.e_vr = 1'(vr);    v.e_dr = 8'(dr);
    v.e_vc = 1'(vc);    v.e_dc = 8'(dc);
    v.e_fr = 1'(fr);    v.e_fc = 1'(fc);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; wr_en = 0; wr_bank = 0; wr_addr = 4'd8; wr_data = 8'h00;
    addr_r = 4'd8; addr_c = 4'd8;
  endtask

  task automatic chk_regs(input int idx, input logic vr, input logic [7:0] dr,
                          input logic vc, input logic [7:0] dc,
                          input logic fr, input logic fc);
    chk("rd_vld_r", idx, 32'(rd_vld_r), 32'(vr));
    chk("rd_data_r", idx, 32'(rd_data_r), 32'(dr));
    chk("rd_vld_c", idx, 32'(rd_vld_c), 32'(vc));
    chk("rd_data_c", idx, 32'(rd_data_c), 32'(dc));
    chk("full_r", idx, 32'(full_r), 32'(fr));
    chk("full_c", idx, 32'(full_c), 32'(fc));
  endtask

  initial begin
    // Fill bank R with 0x10..0x17
    vecs[0] = mk(0,0,0,8,8'h00, 8,8, 0,0, 0,8'h00, 0,8'h00, 0,0);
    for (int i = 0; i < 8; i++) begin
      vecs[1+i] = mk(0,1,0,i,8'h10+i, 8,8, 0,0, 0,8'h00, 0,8'h00, (i == 7) ? 1 : 0, 0);
    end
    // Row read hit; column request on empty bank stalls
    vecs[9]  = mk(0,0,0,8,8'h00, 3,2, 0,1, 1,8'h13, 0,8'h00, 1,0);
    // Write C[2]: flag still high this cycle, read misses on old valid bit
    vecs[10] = mk(0,1,1,2,8'hA5, 8,2, 0,1, 0,8'h13, 0,8'h00, 1,0);
    vecs[11] = mk(0,0,0,8,8'h00, 8,2, 0,0, 0,8'h13, 1,8'hA5, 1,0);
    // Read-before-write on R[3], full_r unaffected by rewrite
    vecs[12] = mk(0,1,0,3,8'h99, 3,8, 0,0, 1,8'h13, 0,8'hA5, 1,0);
    vecs[13] = mk(0,0,0,8,8'h00, 3,8, 0,0, 1,8'h99, 0,8'hA5, 1,0);
    // Clear with simultaneous write of R[5]
    vecs[14] = mk(1,1,0,5,8'h55, 8,8, 0,0, 0,8'h99, 0,8'hA5, 0,0);
    vecs[15] = mk(0,0,0,8,8'h00, 5,2, 0,1, 1,8'h55, 0,8'hA5, 0,0);
    vecs[16] = mk(0,0,0,8,8'h00, 4,8, 1,0, 0,8'h55, 0,8'hA5, 0,0);
    // Out-of-range write must not alias onto entry 0
    vecs[17] = mk(0,1,0,8,8'hEE, 8,8, 0,0, 0,8'h55, 0,8'hA5, 0,0);
    vecs[18] = mk(0,0,0,8,8'h00, 0,8, 1,0, 0,8'h55, 0,8'hA5, 0,0);

    reset = 1'b0;
    idle_inputs();
    #3;
    chk("rst_rfflag", -1, 32'(rfflag), 0);
    chk("rst_cfflag", -1, 32'(cfflag), 0);
    chk_regs(-1, 0, 8'h00, 0, 8'h00, 0, 0);

    @(posedge clk);
    #1 reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      clr = vecs[k].clr; wr_en = vecs[k].wr_en; wr_bank = vecs[k].wr_bank;
      wr_addr = vecs[k].wr_addr; wr_data = vecs[k].wr_data;
      addr_r = vecs[k].addr_r; addr_c = vecs[k].addr_c;
      #1;
      chk("rfflag", k, 32'(rfflag), 32'(vecs[k].e_rf));
      chk("cfflag", k, 32'(cfflag), 32'(vecs[k].e_cf));
      @(posedge clk);
      #1;
      chk_regs(k, vecs[k].e_vr, vecs[k].e_dr, vecs[k].e_vc, vecs[k].e_dc,
               vecs[k].e_fr, vecs[k].e_fc);
    end

    // Mid-frame asynchronous reset: outputs clear with no clock edge
    idle_inputs();
    addr_r = 4'd5;
    @(posedge clk);
    #1;
    chk("pre_rst_vld_r", 100, 32'(rd_vld_r), 1);
    chk("pre_rst_data_r", 100, 32'(rd_data_r), 32'h55);
    #2 reset = 1'b0;
    #1;
    chk("async_rfflag", 101, 32'(rfflag), 1);
    chk("async_cfflag", 101, 32'(cfflag), 0);
    chk_regs(101, 0, 8'h00, 0, 8'h00, 0, 0);
    addr_r = 4'd8;
    #1;
    chk("async_idle_rfflag", 102, 32'(rfflag), 0);
    #2 reset = 1'b1;
    addr_r = 4'd5;
    addr_c = 4'd2;
    #1;
    chk("post_rst_rfflag", 103, 32'(rfflag), 1);
    chk("post_rst_cfflag", 103, 32'(cfflag), 1);
    @(posedge clk);
    #1;
    chk_regs(104, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_buf.md
Name: operand_buf

Overview:
Dual-bank operand store that answers the row/column address requests issued by the stage-2 sequencer. It holds one row operand vector (bank R) and one column operand vector (bank C), each with per-entry valid bits. It returns registered read data. It drives rfflag/cfflag combinationally, so the sequencer stalls while a requested entry has not yet been loaded. A loader fills the banks through a simple write port. A frame clear invalidates all entries between frames.

Parameters:
S, 8, number of entries per bank; an address value >= S (nominally S) is the idle/no-request code
addrwidth, 3, entry index width; address ports are addrwidth+1 bits so the idle code is representable
DW, 8, operand data width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
clr  input  1  frame clear pulse; invalidates all entries of both banks
wr_en  input  1  write strobe
wr_bank  input  1  0 = bank R, 1 = bank C
wr_addr  input  addrwidth+1  write entry index
wr_data  input  DW  write data
addr_r  input  addrwidth+1  row read request; >= S means no request
addr_c  input  addrwidth+1  column read request; >= S means no request
rfflag  output  1  row request pending on an invalid entry (stall)
cfflag  output  1  column request pending on an invalid entry (stall)
rd_data_r  output  DW  registered row operand
rd_vld_r  output  1  rd_data_r updated this cycle
rd_data_c  output  DW  registered column operand
rd_vld_c  output  1  rd_data_c updated this cycle
full_r  output  1  all S entries of bank R valid
full_c  output  1  all S entries of bank C valid

Behaviour:
- Reset (reset=0, asynchronous): all valid bits 0; storage 0; rd_data_r/c=0; rd_vld_r/c=0; cnt_r/cnt_c=0; full_r/c=0. rfflag/cfflag=0 while addresses are idle.
- Write: on a clock edge with wr_en=1 and wr_addr<S, store wr_data into entry wr_addr of the selected bank and set its valid bit. wr_addr>=S is ignored with no state change.
- Rewriting an already-valid entry updates the data only. The valid count is unchanged.
- Valid count: cnt_r/cnt_c are addrwidth+1 bits and track the number of set valid bits. They increment only on a write to an invalid entry. full_x = (cnt_x == S), registered.
- clr: on the edge, all valid bits and both counts go to 0. Storage is untouched.
- clr and wr_en in the same cycle: the clear applies first, then the write. The written entry ends valid and its bank count ends at 1.
- Flags are combinational from registered valid bits: rfflag = (addr_r<S) && !vld_r[addr_r]; cfflag likewise for bank C. A write to the requested entry drops the flag on the cycle after the write edge, never in the same cycle.
- Read, 1-cycle latency, per bank independently:
  - If addr_x<S and the entry is valid at the edge, then rd_data_x <= mem_x[addr_x] and rd_vld_x <= 1.
  - Otherwise rd_vld_x <= 0 and rd_data_x holds its value.
- Read and write of the same entry in the same cycle: the read returns the old data (read-before-write). The flag still uses the old valid bit.
- Idle code (addr>=S): no flag, no read, rd_vld=0. Both banks may be idle, single, or both requested in any cycle.
- Reset asserted mid-frame discards all content immediately. After release, every request stalls until it is reloaded.

Test Plan:
- Reset, then addr_r=8, addr_c=8 -> rfflag=cfflag=0, rd_vld_r=rd_vld_c=0, full_r=full_c=0, rd_data_r=rd_data_c=0.
- Write bank R entries 0..7 with 0x10..0x17 -> full_r=1 one cycle after the last write. Then addr_r=3 -> rd_vld_r=1 and rd_data_r=0x13 on the next cycle. rfflag stays 0.
- Bank C empty, addr_c=2 held -> cfflag=1 continuously. Write C[2]=0xA5 -> cfflag=0 on the cycle after the write edge, and the next edge gives rd_data_c=0xA5, rd_vld_c=1.
- Read R[3] (0x13) while writing R[3]=0x99 in the same cycle -> rd_data_r=0x13. The following read of R[3] returns 0x99. cnt_r stays 8 and full_r stays 1.
- Bank R full; in one cycle clr=1 with wr_en=1, bank R, addr 5 -> next cycle cnt_r=1, full_r=0. addr_r=5 gives rfflag=0. addr_r=4 gives rfflag=1.
- wr_addr=8 with wr_en=1 -> no valid/count change. Then assert reset asynchronously mid-frame -> all outputs return to reset values without a clock edge.
